// File: rtl/mips_pkg.sv
// mips_pkg -- shared definitions for the MIPS-style front end.
//   if_state_e        : instruction-fetch FSM encoding (IDLE, REQ, HOLD)
//   RESET_PC_DEFAULT  : default fetch address after reset
//   INSTR_W           : instruction word width
//   OPCODE_*/JIDX_*   : field positions of the opcode and jump index
//   jump_target()     : builds a J-type target from PC+4 and the index field
package mips_pkg;

  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned JIDX_MSB   = 25;
  localparam int unsigned JIDX_LSB   = 0;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } if_state_e;

  // The jump stays inside the 256 MB region of the delay-slot PC.
  function automatic logic [31:0] jump_target(input logic [3:0]  pc4_hi,
                                              input logic [25:0] jidx);
    return {pc4_hi, jidx, 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel -- combinational next-fetch-address mux.
//   branch_taken_i/branch_target_i : resolved branch from EX (highest priority)
//   jmp_i, ifid_pc4_hi_i, jidx_i   : jump decoded in IF/ID and its target fields
//   seq_addr_i                     : address of the word currently being fetched
//   redirect_o                     : a branch or jump wants the front end
//   next_addr_o                    : redirect target, else seq_addr_i + 4
module pc_next_sel
  import mips_pkg::*;
(
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jmp_i,
  input  logic [3:0]  ifid_pc4_hi_i,
  input  logic [25:0] jidx_i,
  input  logic [31:0] seq_addr_i,
  output logic        redirect_o,
  output logic [31:0] next_addr_o
);

  always_comb begin
    redirect_o = branch_taken_i | jmp_i;
    if (branch_taken_i) begin
      // Fetches are word aligned; low target bits are dropped here.
      next_addr_o = branch_target_i & ~32'd3;
    end else if (jmp_i) begin
      next_addr_o = jump_target(ifid_pc4_hi_i, jidx_i);
    end else begin
      // Wraps modulo 2^32 naturally.
      next_addr_o = seq_addr_i + 32'd4;
    end
  end

endmodule

// File: rtl/ifetch_stage.sv
// ifetch_stage -- instruction fetch stage with IF/ID register.
//   clk, rstN (async, active-low)
//   stall                     : hazard hold from decode
//   branchTaken/branchTarget  : resolved taken branch from EX
//   jmp                       : jump decoded from the word in IF/ID
//   imemReq/imemAddr          : instruction memory request (word aligned)
//   imemAck/imemData          : memory response, same cycle or later
//   instrOut/pcPlus4Out/validOut/opCode : IF/ID register outputs
//   fetchCount/stallCount     : performance counters, built only when the
//                               IFETCH_PERF_EN macro is defined, else tied 0
module ifetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               stall,
  input  logic               branchTaken,
  input  logic [31:0]        branchTarget,
  input  logic               jmp,
  output logic               imemReq,
  output logic [31:0]        imemAddr,
  input  logic               imemAck,
  input  logic [INSTR_W-1:0] imemData,
  output logic [INSTR_W-1:0] instrOut,
  output logic [31:0]        pcPlus4Out,
  output logic               validOut,
  output logic [5:0]         opCode,
  output logic [31:0]        fetchCount,
  output logic [31:0]        stallCount
);

  localparam logic [31:0] RESET_ADDR = {RESET_PC[31:2], 2'b00};

  if_state_e          state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        req_addr_q, req_addr_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [31:0]        pc4_q, pc4_d;
  logic               valid_q, valid_d;
  logic               drop_q, drop_d;
  logic [INSTR_W-1:0] buf_q, buf_d;

  logic               redirect;
  logic [31:0]        next_addr;

  pc_next_sel u_pc_next_sel (
    .branch_taken_i  (branchTaken),
    .branch_target_i (branchTarget),
    .jmp_i           (jmp),
    .ifid_pc4_hi_i   (pc4_q[31:28]),
    .jidx_i          (instr_q[JIDX_MSB:JIDX_LSB]),
    .seq_addr_i      (req_addr_q),
    .redirect_o      (redirect),
    .next_addr_o     (next_addr)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    instr_d    = instr_q;
    pc4_d      = pc4_q;
    // Decode consumes IF/ID whenever it is not stalled; with nothing new it becomes a bubble.
    valid_d    = stall ? valid_q : 1'b0;
    drop_d     = drop_q;
    buf_d      = buf_q;
    imemReq    = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect) begin
          pc_d       = next_addr;
          req_addr_d = next_addr;
          valid_d    = 1'b0;
        end
      end

      REQ: begin
        imemReq = 1'b1;
        if (redirect) begin
          valid_d = 1'b0;
          pc_d    = next_addr;
          if (imemAck) begin
            // Word arriving with the redirect is wrong-path; refetch at once.
            req_addr_d = next_addr;
            drop_d     = 1'b0;
          end else begin
            // Keep the open request stable; its word is thrown away on ack.
            drop_d = 1'b1;
          end
        end else if (imemAck) begin
          if (drop_q) begin
            drop_d     = 1'b0;
            req_addr_d = pc_q;
          end else if (stall) begin
            buf_d   = imemData;
            state_d = HOLD;
          end else begin
            instr_d    = imemData;
            pc4_d      = next_addr;
            valid_d    = 1'b1;
            pc_d       = next_addr;
            req_addr_d = next_addr;
          end
        end
      end

      HOLD: begin
        if (redirect) begin
          valid_d    = 1'b0;
          pc_d       = next_addr;
          req_addr_d = next_addr;
          state_d    = REQ;
        end else if (!stall) begin
          instr_d    = buf_q;
          pc4_d      = next_addr;
          valid_d    = 1'b1;
          pc_d       = next_addr;
          req_addr_d = next_addr;
          state_d    = REQ;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= IDLE;
      pc_q       <= RESET_ADDR;
      req_addr_q <= RESET_ADDR;
      instr_q    <= '0;
      pc4_q      <= '0;
      valid_q    <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      instr_q    <= instr_d;
      pc4_q      <= pc4_d;
      valid_q    <= valid_d;
      drop_q     <= drop_d;
    end
  end

  // NOTE: the hold buffer is pure datapath: it is only read in HOLD, which is
  // entered by writing it, so it needs no reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign imemAddr   = req_addr_q;
  assign instrOut   = instr_q;
  assign pcPlus4Out = pc4_q;
  assign validOut   = valid_q;
  assign opCode     = instr_q[OPCODE_MSB:OPCODE_LSB];

`ifdef IFETCH_PERF_EN
  logic        ifid_load;
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  // A live word enters IF/ID from the memory or from the hold buffer.
  assign ifid_load = !redirect && !stall &&
                     (((state_q == REQ) && imemAck && !drop_q) || (state_q == HOLD));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (ifid_load) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (stall)     stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetchCount = fetch_cnt_q;
  assign stallCount = stall_cnt_q;
`else
  assign fetchCount = '0;
  assign stallCount = '0;
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// tb_ifetch_stage -- self-checking bench for ifetch_stage: directed scenarios
// plus a randomized run against a stream/queue reference model.
module tb_ifetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rstN;
  logic        stall;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        jmp;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic [31:0] instrOut;
  logic [31:0] pcPlus4Out;
  logic        validOut;
  logic [5:0]  opCode;
  logic [31:0] fetchCount;
  logic [31:0] stallCount;

  logic        fixed_en;
  logic [31:0] fixed_word;

  int errors = 0;
  int checks = 0;

  ifetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rstN         (rstN),
    .stall        (stall),
    .branchTaken  (branchTaken),
    .branchTarget (branchTarget),
    .jmp          (jmp),
    .imemReq      (imemReq),
    .imemAddr     (imemAddr),
    .imemAck      (imemAck),
    .imemData     (imemData),
    .instrOut     (instrOut),
    .pcPlus4Out   (pcPlus4Out),
    .validOut     (validOut),
    .opCode       (opCode),
    .fetchCount   (fetchCount),
    .stallCount   (stallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: one fixed jump word at 0x100, a hash elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0800_0040;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign imemData = fixed_en ? fixed_word : mem_word(imemAddr);

  // ---------------- reference model (fetch stream with a word queue) --------
  logic        m_started;
  logic        m_stale;
  logic [31:0] m_stale_addr;
  logic [31:0] m_pc;
  logic [31:0] m_buf[$];
  logic [31:0] m_if_instr;
  logic [31:0] m_if_pc4;
  logic        m_if_valid;
  int          m_fetches;
  int          m_stalls;

  function automatic logic m_req();
    return m_started && (m_buf.size() == 0);
  endfunction

  function automatic logic [31:0] m_addr();
    return m_stale ? m_stale_addr : m_pc;
  endfunction

  task automatic model_reset();
    m_started  = 1'b0;
    m_stale    = 1'b0;
    m_stale_addr = RST_PC;
    m_pc       = RST_PC;
    m_buf.delete();
    m_if_instr = '0;
    m_if_pc4   = '0;
    m_if_valid = 1'b0;
    m_fetches  = 0;
    m_stalls   = 0;
  endtask

  // Advances the model across one clock edge with the given inputs.
  task automatic model_step(input logic st, input logic br, input logic [31:0] tgt,
                            input logic jp, input logic ak);
    logic        req;
    logic        redir;
    logic        accepted;
    logic [31:0] addr;
    logic [31:0] target;
    logic [31:0] word;
    req      = m_req();
    addr     = m_addr();
    redir    = br | jp;
    accepted = req && ak;
    target   = br ? {tgt[31:2], 2'b00} : {m_if_pc4[31:28], m_if_instr[25:0], 2'b00};
    if (st) m_stalls++;
    if (!m_started) begin
      m_started = 1'b1;
      if (redir) begin
        m_pc = target;
        m_if_valid = 1'b0;
      end else if (!st) begin
        m_if_valid = 1'b0;
      end
    end else if (redir) begin
      m_if_valid = 1'b0;
      m_buf.delete();
      if (req && !ak) begin
        if (!m_stale) begin
          m_stale = 1'b1;
          m_stale_addr = addr;
        end
      end else if (accepted) begin
        m_stale = 1'b0;
      end
      m_pc = target;
    end else if (accepted && m_stale) begin
      m_stale = 1'b0;
      if (!st) m_if_valid = 1'b0;
    end else if (accepted && st) begin
      m_buf.push_back(mem_word(addr));
    end else if ((accepted || m_buf.size() != 0) && !st) begin
      word = accepted ? mem_word(addr) : m_buf.pop_front();
      m_if_instr = word;
      m_if_pc4   = m_pc + 32'd4;
      m_pc       = m_pc + 32'd4;
      m_if_valid = 1'b1;
      m_fetches++;
    end else if (!st) begin
      m_if_valid = 1'b0;
    end
  endtask

  // ---------------- helpers -------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    stall = 1'b0; branchTaken = 1'b0; branchTarget = '0; jmp = 1'b0; imemAck = 1'b0;
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
  endtask

  // ---------------- scenarios -----------------------------------------------
  task automatic test_reset();
    rstN = 1'b1; stall = 1'b0; branchTaken = 1'b0; branchTarget = '0; jmp = 1'b0;
    imemAck = 1'b1; fixed_en = 1'b0; fixed_word = '0;
    #2 rstN = 1'b0;
    tick();
    checks++;
    if ({imemReq, validOut} !== 2'b00) begin
      errors++; $display("FAIL reset_ctrl: req/valid=%b required 00", {imemReq, validOut});
    end
    checks++;
    if ({instrOut, pcPlus4Out, imemAddr} !== {32'h0, 32'h0, RST_PC}) begin
      errors++; $display("FAIL reset_regs: instr=%h pc4=%h addr=%h required 0/0/%h",
                         instrOut, pcPlus4Out, imemAddr, RST_PC);
    end
    checks++;
    if ({fetchCount, stallCount} !== 64'h0) begin
      errors++; $display("FAIL reset_counters: %h/%h required 0/0", fetchCount, stallCount);
    end
  endtask

  task automatic test_reset_release();
    fixed_en = 1'b1; fixed_word = 32'h8C01_0004;
    do_reset();
    imemAck = 1'b1;
    checks++;
    if (imemReq !== 1'b0) begin
      errors++; $display("FAIL release_idle: req=%b required 0", imemReq);
    end
    tick();
    checks++;
    if ({imemReq, imemAddr} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL release_first: req=%b addr=%h required 1/0", imemReq, imemAddr);
    end
    tick();
    checks++;
    if ({imemAddr, pcPlus4Out, opCode, validOut} !== {32'h4, 32'h4, 6'b100011, 1'b1}) begin
      errors++; $display("FAIL release_second: addr=%h pc4=%h op=%b valid=%b required 4/4/100011/1",
                         imemAddr, pcPlus4Out, opCode, validOut);
    end
    tick();
    checks++;
    if ({imemAddr, pcPlus4Out} !== {32'h8, 32'h8}) begin
      errors++; $display("FAIL release_third: addr=%h pc4=%h required 8/8", imemAddr, pcPlus4Out);
    end
    fixed_en = 1'b0;
  endtask

  task automatic test_ack_delay();
    do_reset();
    imemAck = 1'b1;
    repeat (5) tick();
    imemAck = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      checks++;
      if ({imemReq, imemAddr} !== {1'b1, 32'h10}) begin
        errors++; $display("FAIL delay_addr[%0d]: req=%b addr=%h required 1/10", i, imemReq, imemAddr);
      end
      if (i > 0) begin
        checks++;
        if (validOut !== 1'b0) begin
          errors++; $display("FAIL delay_valid[%0d]: valid=%b required 0", i, validOut);
        end
      end
    end
    imemAck = 1'b1;
    tick();
    checks++;
    if ({validOut, pcPlus4Out, instrOut, imemAddr} !== {1'b1, 32'h14, mem_word(32'h10), 32'h14}) begin
      errors++; $display("FAIL delay_ack: valid=%b pc4=%h instr=%h addr=%h required 1/14/%h/14",
                         validOut, pcPlus4Out, instrOut, imemAddr, mem_word(32'h10));
    end
  endtask

  task automatic test_stall_hold();
    do_reset();
    imemAck = 1'b1;
    repeat (9) tick();
    checks++;
    if (imemAddr !== 32'h20) begin
      errors++; $display("FAIL stall_setup: addr=%h required 20", imemAddr);
    end
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({imemReq, validOut, instrOut, pcPlus4Out} !== {1'b0, 1'b1, mem_word(32'h1C), 32'h20}) begin
        errors++; $display("FAIL stall_hold[%0d]: req=%b valid=%b instr=%h pc4=%h required 0/1/%h/20",
                           i, imemReq, validOut, instrOut, pcPlus4Out, mem_word(32'h1C));
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if ({imemReq, imemAddr, instrOut, pcPlus4Out} !== {1'b1, 32'h24, mem_word(32'h20), 32'h24}) begin
      errors++; $display("FAIL stall_release: req=%b addr=%h instr=%h pc4=%h required 1/24/%h/24",
                         imemReq, imemAddr, instrOut, pcPlus4Out, mem_word(32'h20));
    end
  endtask

  task automatic test_jump();
    do_reset();
    imemAck = 1'b1;
    tick();
    branchTaken = 1'b1; branchTarget = 32'h100;
    tick();
    branchTaken = 1'b0;
    checks++;
    if ({imemAddr, validOut} !== {32'h100, 1'b0}) begin
      errors++; $display("FAIL jump_setup_branch: addr=%h valid=%b required 100/0", imemAddr, validOut);
    end
    tick();
    checks++;
    if ({instrOut, pcPlus4Out, opCode} !== {32'h0800_0040, 32'h104, 6'b000010}) begin
      errors++; $display("FAIL jump_setup_word: instr=%h pc4=%h op=%b required 08000040/104/000010",
                         instrOut, pcPlus4Out, opCode);
    end
    jmp = 1'b1;
    tick();
    jmp = 1'b0;
    checks++;
    if ({validOut, imemAddr} !== {1'b0, 32'h100}) begin
      errors++; $display("FAIL jump_redirect: valid=%b addr=%h required 0/100", validOut, imemAddr);
    end
  endtask

  // Runs straight after test_jump: IF/ID still holds the jump word from 0x100.
  task automatic test_branch_priority();
    imemAck = 1'b0;
    tick();
    branchTaken = 1'b1; branchTarget = 32'h200; jmp = 1'b1;
    tick();
    branchTaken = 1'b0; jmp = 1'b0;
    checks++;
    if ({imemReq, imemAddr, validOut} !== {1'b1, 32'h100, 1'b0}) begin
      errors++; $display("FAIL prio_open: req=%b addr=%h valid=%b required 1/100/0",
                         imemReq, imemAddr, validOut);
    end
    imemAck = 1'b1;
    tick();
    checks++;
    if ({imemAddr, validOut} !== {32'h200, 1'b0}) begin
      errors++; $display("FAIL prio_drop: addr=%h valid=%b required 200/0", imemAddr, validOut);
    end
    tick();
    checks++;
    if ({validOut, pcPlus4Out, instrOut} !== {1'b1, 32'h204, mem_word(32'h200)}) begin
      errors++; $display("FAIL prio_target: valid=%b pc4=%h instr=%h required 1/204/%h",
                         validOut, pcPlus4Out, instrOut, mem_word(32'h200));
    end
  endtask

  task automatic test_wrap();
    do_reset();
    imemAck = 1'b1;
    tick();
    branchTaken = 1'b1; branchTarget = 32'hFFFF_FFFC;
    tick();
    branchTaken = 1'b0;
    tick();
    checks++;
    if ({pcPlus4Out, instrOut, imemAddr, validOut} !== {32'h0, mem_word(32'hFFFF_FFFC), 32'h0, 1'b1}) begin
      errors++; $display("FAIL wrap: pc4=%h instr=%h addr=%h valid=%b required 0/%h/0/1",
                         pcPlus4Out, instrOut, imemAddr, validOut, mem_word(32'hFFFF_FFFC));
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    imemAck = 1'b0;
    tick();
    branchTaken = 1'b1; branchTarget = 32'h40;
    tick();
    branchTaken = 1'b0;
    imemAck = 1'b1;
    tick();
    imemAck = 1'b0;
    tick();
    checks++;
    if ({imemReq, imemAddr} !== {1'b1, 32'h40}) begin
      errors++; $display("FAIL areset_setup: req=%b addr=%h required 1/40", imemReq, imemAddr);
    end
    #2 rstN = 1'b0;
    #1;
    checks++;
    if ({imemReq, validOut, imemAddr} !== {1'b0, 1'b0, RST_PC}) begin
      errors++; $display("FAIL areset_now: req=%b valid=%b addr=%h required 0/0/%h",
                         imemReq, validOut, imemAddr, RST_PC);
    end
    @(posedge clk);
    #1;
    rstN = 1'b1;
    imemAck = 1'b1;
    tick();
    checks++;
    if ({imemReq, imemAddr} !== {1'b1, RST_PC}) begin
      errors++; $display("FAIL areset_restart: req=%b addr=%h required 1/%h", imemReq, imemAddr, RST_PC);
    end
    tick();
    checks++;
    if ({validOut, pcPlus4Out, instrOut} !== {1'b1, RST_PC + 32'd4, mem_word(RST_PC)}) begin
      errors++; $display("FAIL areset_first_word: valid=%b pc4=%h instr=%h required 1/%h/%h",
                         validOut, pcPlus4Out, instrOut, RST_PC + 32'd4, mem_word(RST_PC));
    end
  endtask

  task automatic test_random();
    logic        st, br, jp, ak;
    logic [31:0] tgt;
    logic [31:0] exp_fetch, exp_stall;
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      checks++;
      if ({imemReq, imemAddr, instrOut, pcPlus4Out, validOut, opCode} !==
          {m_req(), m_addr(), m_if_instr, m_if_pc4, m_if_valid, m_if_instr[31:26]}) begin
        errors++;
        $display("FAIL random[%0d]: req=%b addr=%h instr=%h pc4=%h valid=%b required %b/%h/%h/%h/%b",
                 cyc, imemReq, imemAddr, instrOut, pcPlus4Out, validOut,
                 m_req(), m_addr(), m_if_instr, m_if_pc4, m_if_valid);
      end
      st  = ($urandom_range(0, 3) == 0);
      ak  = ($urandom_range(0, 2) != 0);
      br  = ($urandom_range(0, 15) == 0);
      jp  = ($urandom_range(0, 19) == 0);
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : (32'($urandom_range(0, 1023)) << 2);
      stall = st; imemAck = ak; branchTaken = br; branchTarget = tgt; jmp = jp;
      model_step(st, br, tgt, jp, ak);
      tick();
    end
`ifdef IFETCH_PERF_EN
    exp_fetch = 32'(m_fetches);
    exp_stall = 32'(m_stalls);
`else
    exp_fetch = 32'h0;
    exp_stall = 32'h0;
`endif
    checks++;
    if (fetchCount !== exp_fetch) begin
      errors++; $display("FAIL fetch_count: got %0d required %0d", fetchCount, exp_fetch);
    end
    checks++;
    if (stallCount !== exp_stall) begin
      errors++; $display("FAIL stall_count: got %0d required %0d", stallCount, exp_stall);
    end
  endtask

  initial begin
    test_reset();
    test_reset_release();
    test_ack_delay();
    test_stall_hold();
    test_jump();
    test_branch_priority();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifetch_stage.md
IFETCH_STAGE -- requirements
Module: ifetch_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, fetch address loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rstN  input  1  reset, asynchronous, active-low.
REQ-004 stall  input  1  hazard hold from decode; freezes PC and the IF/ID outputs.
REQ-005 branchTaken  input  1  resolved taken branch (branch & zero from EX).
REQ-006 branchTarget  input  32  full branch target address.
REQ-007 jmp  input  1  jump decoded from the instruction in IF/ID.
REQ-008 imemReq  output  1  instruction memory request.
REQ-009 imemAddr  output  32  request address, word aligned.
REQ-010 imemAck  input  1  data valid on imemData this cycle; may arrive in the request cycle or later.
REQ-011 imemData  input  32  instruction word.
REQ-012 instrOut  output  32  IF/ID instruction register.
REQ-013 pcPlus4Out  output  32  IF/ID PC+4 of instrOut.
REQ-014 validOut  output  1  instrOut holds a live instruction.
REQ-015 opCode  output  6  instrOut[31:26], fed to the main control decoder.
REQ-016 fetchCount, stallCount  output  32 each  performance counters (see Configuration).

Function
REQ-017 FSM states SHALL be IDLE, REQ and HOLD; the reset state SHALL be IDLE.
REQ-018 IDLE: imemReq=0; next state REQ unconditionally, so the first request is asserted one cycle after reset release.
REQ-019 REQ: imemReq=1 and imemAddr=reqAddr; reqAddr SHALL stay stable until imemAck is seen.
REQ-020 REQ with ack, no stall and no redirect: instrOut<=imemData, pcPlus4Out<=reqAddr+4, validOut<=1, pc<=reqAddr+4; the state stays REQ.
REQ-021 Back-to-back acks SHALL give one instruction per cycle (zero-bubble throughput).
REQ-022 REQ with ack and stall: the word SHALL be buffered internally and the next state SHALL be HOLD; imemReq=0 while in HOLD.
REQ-023 HOLD with stall released: the buffered word SHALL move to IF/ID, pc<=+4, and the next state SHALL be REQ.
REQ-024 While stall=1 and there is no redirect: instrOut, pcPlus4Out, validOut and pc SHALL hold.
REQ-025 Redirect SHALL be branchTaken|jmp and SHALL override stall.
REQ-026 Redirect priority: branchTaken beats jmp.
REQ-027 Jump target SHALL be {pcPlus4Out[31:28], instrOut[25:0], 2'b00}.
REQ-028 On a redirect edge: validOut<=0, pc<=target, and any HOLD buffer SHALL be discarded, with HOLD -> REQ.
REQ-029 Redirect in REQ with ack in the same cycle: the data SHALL be dropped and reqAddr<=target.
REQ-030 Redirect in REQ before ack: a drop flag SHALL be set and the request SHALL stay open; the acked word SHALL be discarded, then a new request SHALL be issued to the target.
REQ-031 pc arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC+4 = 0.
REQ-032 imemAck with imemReq=0 SHALL be ignored.

Reset
REQ-033 Reset values: pc=reqAddr=RESET_PC, state IDLE, instrOut=0, pcPlus4Out=0, validOut=0, drop flag=0, counters=0, imemReq=0.
REQ-034 Reset mid-request SHALL drop imemReq immediately (asynchronous) and SHALL abandon the outstanding access.

Configuration
REQ-035 With IFETCH_PERF_EN defined: fetchCount SHALL increment per word written to IF/ID with validOut=1, and stallCount SHALL increment per cycle with stall=1; both wrap at 2^32.
REQ-036 Without IFETCH_PERF_EN: both ports SHALL remain present and tied to 0, and no counter flops SHALL be built.

Structure
REQ-037 A shared package (mips_pkg) SHALL hold the FSM state encoding, the RESET_PC default, the opcode field positions [31:26] and [25:0], and the instruction width of 32.
REQ-038 One sub-module, pc_next_sel, SHALL be the combinational target mux (branch/jump/+4); everything else SHALL be flat.

Verification
REQ-039 Reset release with imemAck tied 1 and imemData=0x8C010004 -> imemAddr 0,4,8 on successive cycles; opCode=6'b100011, pcPlus4Out=4.
REQ-040 Ack delayed 3 cycles at address 0x10 -> imemAddr held at 0x10 for all 4 request cycles; validOut=0 until the ack edge.
REQ-041 stall=1 for 2 cycles during an ack at 0x20 -> IF/ID unchanged, state HOLD, imemReq=0; after release, instrOut = word of 0x20 and the next imemAddr is 0x24.
REQ-042 jmp=1 with instrOut=0x08000040 and pcPlus4Out=0x0000_0104 -> validOut=0 next cycle, next imemAddr=0x0000_0100.
REQ-043 branchTaken=1 (target 0x200) and jmp=1 in the same cycle, request pending -> pending word dropped, next request at 0x200.
REQ-044 rstN low mid-wait -> imemReq=0 immediately; after release, fetch restarts at RESET_PC.
